ps2_dev_tx: RTL
===============

Name: ps2_dev_tx

Overview:
- Parametrised, single-channel PS/2 device-side transmitter; successor to the fixed 8-byte keyboard/mouse transmitters inside the IO controller.
- Buffers bytes from the SPI command decoder and serialises them as PS/2 frames onto emulated open-collector clock/data lines.
- Adds over the fixed version: configurable FIFO depth and clock divider, host-inhibit sensing with abort and retransmit, flush, occupancy and overflow status, and a frame-done strobe.
- Instantiated once per PS/2 device (keyboard, mouse) in the clk_sys domain.

Parameters:
- FIFO_BITS, 3: log2 of FIFO depth in bytes (depth = 2**FIFO_BITS, range 1..8).
- PS2DIV, 20: divider; internal PS/2 clock half-period = PS2DIV+1 clk_sys cycles.

Ports:
- clk_sys  in  1  system clock; all logic rises on it.
- reset  in  1  synchronous reset, active-high.
- wr  in  1  one-cycle write strobe for din.
- din  in  8  byte to queue.
- flush  in  1  synchronous clear of FIFO, overflow and the frame in flight.
- ps2_clk_in  in  1  sensed PS/2 clock line (host may pull low); asynchronous, double-flopped inside.
- ps2_clk_out  out  1  emulated clock; 1 = released.
- ps2_data_out  out  1  emulated data; 1 = released.
- fifo_level  out  FIFO_BITS+1  bytes queued, including the byte in flight.
- fifo_full  out  1  fifo_level == 2**FIFO_BITS.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  frame in progress (state != IDLE).
- tx_done  out  1  one-cycle pulse when a frame completes its stop bit.

Behaviour:
- Reset values:
  - ps2_clk_out = 1, ps2_data_out = 1.
  - fifo_level = 0, fifo_full = 0, overflow = 0, busy = 0, tx_done = 0.
  - Divider count = 0, internal clk_ps2 = 0, state = IDLE.
- Divider:
  - Counts 0..PS2DIV. At PS2DIV it toggles clk_ps2 and wraps to 0.
  - "tick" is a one-cycle pulse on each clk_ps2 0->1 transition, i.e. every 2*(PS2DIV+1) cycles.
  - The divider free-runs and is not reset by flush.
- ps2_clk_out = clk_ps2 OR (state == IDLE). Data changes only on tick, with clock high; the host samples on the falling edge.
- Inhibit:
  - inh = synchronised ps2_clk_in is 0 while ps2_clk_out is 1, i.e. the host holds the clock low.
  - 2-flop synchroniser, so 2-cycle detection latency.
- FSM, evaluated only on tick unless noted:
  - IDLE: if FIFO non-empty and not inh: data <= 0 (start bit), load shifter with head byte (head is not popped), parity <= 1, state <= 1.
  - 1..8: data <= shifter[0]; shift right; if the bit is 1, toggle parity (odd parity).
  - 9: data <= parity.
  - 10: data <= 1 (stop bit).
  - 11: pop head, tx_done pulses this cycle, state <= IDLE.
  - A frame is 12 ticks from start to IDLE. Back-to-back frames start on the next tick after returning to IDLE.
- Abort, checked every cycle rather than only on tick:
  - Applies when inh is seen in any state 1..10.
  - Response: state <= IDLE, data <= 1, no pop, no tx_done.
  - The same byte is retransmitted from its start bit once inh clears.
  - inh in IDLE only blocks the start.
- FIFO:
  - Circular buffer; pointers wrap modulo depth.
  - A wr with the FIFO full is dropped and sets overflow.
  - A wr in the same cycle as a pop while full is accepted (level stays full).
  - A wr while non-full always increments the level, unless a pop coincides, in which case the level is unchanged.
- flush:
  - Empties the FIFO, clears overflow, forces state IDLE and data = 1 in that cycle.
  - A wr coincident with flush is discarded.
  - Flush wins over a coincident pop and tx_done (tx_done suppressed).
- reset mid-frame: lines release in the same edge; no partial frame resumes.
- fifo_level and fifo_full are registered and reflect updates one cycle after the causing edge.

Test Plan (PS2DIV=2, tick every 6 cycles, FIFO_BITS=3):
- Single byte: write 0x1C to empty FIFO, host idle -> next tick data=0, then bits 0,0,1,1,1,0,0,0, parity 0, stop 1 sampled on the 11 ps2_clk_out falling edges; tx_done one cycle on the 12th tick; fifo_level 1->0.
- Parity: write 0x00 -> parity bit 1; write 0xFF -> parity bit 1; write 0x01 -> parity bit 0.
- Overflow: 9 writes of 0x01..0x09 while inh is held -> fifo_full=1, level=8, overflow=1. Release inh -> bytes 0x01..0x08 sent in order; 0x09 never appears.
- Inhibit abort: during data bit 4 of 0xAA, pull ps2_clk_in low for 100 cycles -> within 3 cycles data=1 and busy=0, no tx_done; after release the full 0xAA frame is resent and level ends at 0.
- Simultaneous events: FIFO full with wr in the pop cycle -> level remains 8, overflow stays 0. Flush asserted mid-frame with a coincident wr -> level 0, overflow 0, lines released, nothing transmitted afterward.
- Reset mid-frame at state 6 -> next cycle all outputs at reset values; divider restarts from 0.

Source files
------------

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: byte FIFO feeding an odd-parity PS/2 frame serialiser
// on emulated open-collector lines, with host-inhibit abort/retransmit and flush.
module ps2_dev_tx #(
   parameter int FIFO_BITS = 3,
   parameter int PS2DIV    = 20
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [7:0]           din,
   input  logic                 flush,
   input  logic                 ps2_clk_in,
   output logic                 ps2_clk_out,
   output logic                 ps2_data_out,
   output logic [FIFO_BITS:0]   fifo_level,
   output logic                 fifo_full,
   output logic                 overflow,
   output logic                 busy,
   output logic                 tx_done
);
   localparam int DEPTH = 2 ** FIFO_BITS;
   localparam int DIV_W = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;
   localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(PS2DIV);
   localparam logic [DIV_W-1:0]     DIV_ONE    = DIV_W'(1);
   localparam logic [FIFO_BITS:0]   FULL_LEVEL = (FIFO_BITS + 1)'(DEPTH);
   localparam logic [FIFO_BITS:0]   LEVEL_ONE  = (FIFO_BITS + 1)'(1);
   localparam logic [FIFO_BITS-1:0] PTR_ONE    = FIFO_BITS'(1);

   typedef enum logic [3:0] {
      IDLE, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, PARITY, STOP, DONE
   } state_t;

   state_t                state, state_n;
   logic [DIV_W-1:0]      div_cnt;
   logic                  clk_ps2;
   logic                  tick;
   logic [1:0]            clk_sync;
   logic                  inh;
   logic                  abort;
   logic [7:0]            mem [DEPTH];
   logic [FIFO_BITS-1:0]  rd_ptr, wr_ptr;
   logic                  push, pop;
   logic [FIFO_BITS:0]    level_n;
   logic [7:0]            shifter, shifter_n;
   logic                  parity, parity_n;
   logic                  data, data_n;

   // Free-running divider; flush deliberately leaves its phase alone.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div_cnt <= '0;
         clk_ps2 <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         clk_ps2 <= ~clk_ps2;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   assign tick = (div_cnt == DIV_LAST) && !clk_ps2;

   always_ff @(posedge clk_sys) begin
      if (reset) clk_sync <= 2'b11;
      else       clk_sync <= {clk_sync[0], ps2_clk_in};
   end

   // Inhibit only means something while we are releasing the clock ourselves.
   assign ps2_clk_out  = clk_ps2 | (state == IDLE);
   assign inh          = ps2_clk_out && !clk_sync[1];
   assign abort        = inh && (state != IDLE) && (state != DONE);
   assign busy         = (state != IDLE);
   assign ps2_data_out = data;
   assign tx_done      = pop;

   assign push = wr && !flush && !reset && (!fifo_full || pop);

   always_comb begin
      level_n = fifo_level;
      if (push && !pop)      level_n = fifo_level + LEVEL_ONE;
      else if (pop && !push) level_n = fifo_level - LEVEL_ONE;
   end

   always_ff @(posedge clk_sys) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_sys) begin
      if (reset || flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
         fifo_full  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         fifo_level <= level_n;
         fifo_full  <= (level_n == FULL_LEVEL);
         if (wr && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         data    <= 1'b1;
         shifter <= '0;
         parity  <= 1'b1;
      end else begin
         state   <= state_n;
         data    <= data_n;
         shifter <= shifter_n;
         parity  <= parity_n;
      end
   end

   // The head byte stays queued until its stop bit is out, so an abort simply
   // returns to IDLE and the same byte is picked up again.
   always_comb begin
      state_n   = state;
      data_n    = data;
      shifter_n = shifter;
      parity_n  = parity;
      pop       = 1'b0;
      if (flush || abort) begin
         state_n = IDLE;
         data_n  = 1'b1;
      end else if (tick) begin
         case (state)
            IDLE: begin
               if ((fifo_level != '0) && !inh) begin
                  data_n    = 1'b0;
                  shifter_n = mem[rd_ptr];
                  parity_n  = 1'b1;
                  state_n   = BIT0;
               end
            end
            BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
               data_n    = shifter[0];
               shifter_n = {1'b0, shifter[7:1]};
               parity_n  = parity ^ shifter[0];
               state_n   = state_t'(state + 4'd1);
            end
            PARITY: begin
               data_n  = parity;
               state_n = STOP;
            end
            STOP: begin
               data_n  = 1'b1;
               state_n = DONE;
            end
            DONE: begin
               pop     = !reset;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule
